// File: rtl/adder_tree_pipe.sv
// Pipelined signed adder tree: NUM_INPUTS samples -> one registered sum, latency $clog2(NUM_INPUTS)+1.
// Optional macro ADDER_TREE_SAT_EN saturates (instead of wraps) when OUT_WIDTH is narrower than the exact sum.
module adder_tree_pipe #(
  parameter int DATA_WIDTH = 18,
  parameter int NUM_INPUTS = 10,
  parameter int OUT_WIDTH  = DATA_WIDTH + $clog2(NUM_INPUTS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 ce,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]     in_data,
  input  logic                                 in_valid,
  output logic signed [OUT_WIDTH-1:0]          sum,
  output logic                                 sum_valid,
  output logic                                 sat_flag
);

  localparam int LEVELS = $clog2(NUM_INPUTS);
  localparam int FW     = DATA_WIDTH + LEVELS;

  // Node count after lvl halvings equals ceil(NUM_INPUTS / 2^lvl).
  function automatic int level_nodes(input int lvl);
    return (NUM_INPUTS + (1 << lvl) - 1) >> lvl;
  endfunction

  if (NUM_INPUTS < 1 || NUM_INPUTS > 64 || OUT_WIDTH < 2 || OUT_WIDTH > FW) begin : g_bad_param
    $error("adder_tree_pipe: illegal parameter combination");
  end

  // Every level is carried at full width so the levels share one array; each node
  // register itself is only as wide as its level needs.
  logic signed [FW-1:0] tree [LEVELS+1][NUM_INPUTS];

  genvar gi, gj;

  for (gj = 0; gj < NUM_INPUTS; gj++) begin : g_in
    assign tree[0][gj] = FW'(signed'(in_data[gj*DATA_WIDTH +: DATA_WIDTH]));
  end

  for (gi = 1; gi <= LEVELS; gi++) begin : g_level
    localparam int NW    = DATA_WIDTH + gi;
    localparam int NPREV = level_nodes(gi - 1);
    localparam int NCUR  = level_nodes(gi);
    for (gj = 0; gj < NUM_INPUTS; gj++) begin : g_node
      if (gj < NCUR) begin : g_live
        logic signed [NW-1:0] node_reg;
        if (2*gj + 1 < NPREV) begin : g_add
          always_ff @(posedge clk) begin
            if (rst) begin
              node_reg <= '0;
            end else if (ce) begin
              node_reg <= NW'(tree[gi-1][2*gj] + tree[gi-1][2*gj+1]);
            end
          end
        end else begin : g_pass
          // Odd leftover is simply delayed one stage, keeping all paths aligned.
          always_ff @(posedge clk) begin
            if (rst) begin
              node_reg <= '0;
            end else if (ce) begin
              node_reg <= NW'(tree[gi-1][2*gj]);
            end
          end
        end
        assign tree[gi][gj] = FW'(node_reg);
      end else begin : g_unused
        assign tree[gi][gj] = '0;
      end
    end
  end

  logic signed [FW-1:0]        full_sum;
  logic signed [OUT_WIDTH-1:0] sum_next;
  logic                        sat_next;

  assign full_sum = tree[LEVELS][0];

  if (OUT_WIDTH >= FW) begin : g_full
    assign sum_next = OUT_WIDTH'(full_sum);
    assign sat_next = 1'b0;
  end else begin : g_reduce
`ifdef ADDER_TREE_SAT_EN
    localparam logic signed [FW-1:0] MAX_V = FW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [FW-1:0] MIN_V = ~MAX_V;
    always_comb begin
      sum_next = OUT_WIDTH'(full_sum);
      sat_next = 1'b0;
      if (full_sum > MAX_V) begin
        sum_next = OUT_WIDTH'(MAX_V);
        sat_next = 1'b1;
      end else if (full_sum < MIN_V) begin
        sum_next = OUT_WIDTH'(MIN_V);
        sat_next = 1'b1;
      end
    end
`else
    assign sum_next = OUT_WIDTH'(full_sum);
    assign sat_next = 1'b0;
`endif
  end

  // The last valid stage lines up with the output register, so it drives sum_valid directly.
  logic [LEVELS:0] valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
    end else if (ce) begin
      valid_reg[0] <= in_valid;
      for (int i = 1; i <= LEVELS; i++) begin
        valid_reg[i] <= valid_reg[i-1];
      end
    end
  end

  assign sum_valid = valid_reg[LEVELS];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum      <= '0;
      sat_flag <= 1'b0;
    end else if (ce) begin
      sum      <= sum_next;
      sat_flag <= sat_next;
    end
  end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Scoreboard bench for adder_tree_pipe: four parameterisations share clk/ce/rst/in_valid
// and one sample table; expected sums are queued with the enabled-cycle they are due on.
module tb_adder_tree_pipe;

  localparam int ND = 4;
  localparam int N_IN [ND] = '{10, 10, 1, 5};
  localparam int OW   [ND] = '{22, 20, 18, 21};
  localparam int FWA  [ND] = '{22, 22, 18, 21};
  localparam int LAT  [ND] = '{5, 5, 1, 4};

  logic clk;
  logic rst;
  logic ce;
  logic in_valid;
  int   smp [10];

  logic [179:0] data10;
  logic [89:0]  data5;
  logic [17:0]  data1;

  logic signed [21:0] sum0;
  logic signed [19:0] sum1;
  logic signed [17:0] sum2;
  logic signed [20:0] sum3;
  logic v0, v1, v2, v3;
  logic s0, s1, s2, s3;

  int n_checks = 0;
  int n_errors = 0;

  always_comb begin
    data10 = '0;
    data5  = '0;
    for (int k = 0; k < 10; k++) data10[k*18 +: 18] = smp[k][17:0];
    for (int k = 0; k < 5; k++)  data5[k*18 +: 18]  = smp[k][17:0];
    data1 = smp[0][17:0];
  end

  adder_tree_pipe #(.DATA_WIDTH(18), .NUM_INPUTS(10)) u_def (
    .clk(clk), .rst(rst), .ce(ce), .in_data(data10), .in_valid(in_valid),
    .sum(sum0), .sum_valid(v0), .sat_flag(s0));

  adder_tree_pipe #(.DATA_WIDTH(18), .NUM_INPUTS(10), .OUT_WIDTH(20)) u_ow20 (
    .clk(clk), .rst(rst), .ce(ce), .in_data(data10), .in_valid(in_valid),
    .sum(sum1), .sum_valid(v1), .sat_flag(s1));

  adder_tree_pipe #(.DATA_WIDTH(18), .NUM_INPUTS(1)) u_n1 (
    .clk(clk), .rst(rst), .ce(ce), .in_data(data1), .in_valid(in_valid),
    .sum(sum2), .sum_valid(v2), .sat_flag(s2));

  adder_tree_pipe #(.DATA_WIDTH(18), .NUM_INPUTS(5)) u_n5 (
    .clk(clk), .rst(rst), .ce(ce), .in_data(data5), .in_valid(in_valid),
    .sum(sum3), .sum_valid(v3), .sat_flag(s3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Exact sum of the first N_IN[d] samples, reduced to that instance's output width.
  function automatic void model(input int d, output longint val, output bit sat);
    longint s;
    longint hi;
    longint lo;
    s   = 0;
    sat = 1'b0;
    for (int k = 0; k < N_IN[d]; k++) s += longint'(smp[k]);
    val = s;
    if (OW[d] < FWA[d]) begin
      hi = (64'sd1 <<< (OW[d] - 1)) - 1;
      lo = -hi - 1;
`ifdef ADDER_TREE_SAT_EN
      if (s > hi) begin
        val = hi;
        sat = 1'b1;
      end else if (s < lo) begin
        val = lo;
        sat = 1'b1;
      end
`else
      val = (s <<< (64 - OW[d])) >>> (64 - OW[d]);
`endif
    end
  endfunction

  longint q_sum [ND][$];
  bit     q_sat [ND][$];
  int     q_due [ND][$];
  int     ecnt    = 0;
  bit     started = 1'b0;
  bit     last_rst;
  bit     last_ce;

  // Scoreboard producer: every sampled input gets an expected result and due cycle.
  initial begin
    forever begin
      @(posedge clk);
      last_rst = rst;
      last_ce  = ce;
      started  = 1'b1;
      if (rst) begin
        for (int d = 0; d < ND; d++) begin
          q_sum[d].delete();
          q_sat[d].delete();
          q_due[d].delete();
        end
      end else if (ce) begin
        ecnt++;
        if (in_valid) begin
          for (int d = 0; d < ND; d++) begin
            longint ev;
            bit     es;
            model(d, ev, es);
            q_sum[d].push_back(ev);
            q_sat[d].push_back(es);
            q_due[d].push_back(ecnt + LAT[d] - 1);
          end
        end
      end
    end
  end

  bit     hold_v [ND];
  bit     hold_k [ND];
  longint hold_s [ND];
  bit     hold_t [ND];

  // Scoreboard consumer, sampling half a cycle after each active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        for (int d = 0; d < ND; d++) begin
          longint gs;
          bit     gv;
          bit     gt;
          bit     ev;
          longint es;
          bit     et;
          case (d)
            0:       begin gs = sum0; gv = v0; gt = s0; end
            1:       begin gs = sum1; gv = v1; gt = s1; end
            2:       begin gs = sum2; gv = v2; gt = s2; end
            default: begin gs = sum3; gv = v3; gt = s3; end
          endcase
          if (last_rst) begin
            check_val($sformatf("rst_sum_d%0d", d), gs, 0);
            check_val($sformatf("rst_valid_d%0d", d), longint'(gv), 0);
            check_val($sformatf("rst_sat_d%0d", d), longint'(gt), 0);
            hold_v[d] = 1'b0;
            hold_k[d] = 1'b1;
            hold_s[d] = 0;
            hold_t[d] = 1'b0;
          end else if (!last_ce) begin
            check_val($sformatf("hold_valid_d%0d", d), longint'(gv), longint'(hold_v[d]));
            if (hold_k[d]) begin
              check_val($sformatf("hold_sum_d%0d", d), gs, hold_s[d]);
              check_val($sformatf("hold_sat_d%0d", d), longint'(gt), longint'(hold_t[d]));
            end
          end else begin
            ev = (q_due[d].size() > 0) && (q_due[d][0] == ecnt);
            check_val($sformatf("valid_d%0d", d), longint'(gv), longint'(ev));
            hold_v[d] = ev;
            hold_k[d] = ev;
            if (ev) begin
              es = q_sum[d].pop_front();
              et = q_sat[d].pop_front();
              void'(q_due[d].pop_front());
              $display("d%0d cycle %0d: sum=%0d sat=%0d (expected %0d sat %0d)",
                       d, ecnt, gs, gt, es, et);
              check_val($sformatf("sum_d%0d", d), gs, es);
              check_val($sformatf("sat_d%0d", d), longint'(gt), longint'(et));
              hold_s[d] = es;
              hold_t[d] = et;
            end
          end
        end
      end
    end
  end

  task automatic cyc(input bit v, input bit c, input bit r);
    in_valid = v;
    ce       = c;
    rst      = r;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int base, input int step);
    for (int k = 0; k < 10; k++) smp[k] = base + step * k;
  endtask

  initial begin
    rst = 1'b1;
    ce = 1'b1;
    in_valid = 1'b0;
    fill(0, 0);
    repeat (2) @(posedge clk);
    #1;

    // Single ramp 1..10
    fill(1, 1);
    cyc(1, 1, 0);
    fill(0, 0);
    repeat (7) cyc(0, 1, 0);

    // Full-scale positive then negative, back to back
    fill(131071, 0);
    cyc(1, 1, 0);
    fill(-131072, 0);
    cyc(1, 1, 0);
    fill(0, 0);
    repeat (7) cyc(0, 1, 0);

    // Stall three cycles mid-flight
    fill(1, 1);
    cyc(1, 1, 0);
    fill(0, 0);
    repeat (2) cyc(0, 1, 0);
    repeat (3) cyc(0, 0, 0);
    repeat (6) cyc(0, 1, 0);

    // Continuous stream with a one-cycle reset
    fill(1, 1);
    repeat (4) cyc(1, 1, 0);
    cyc(1, 1, 1);
    repeat (6) cyc(1, 1, 0);
    repeat (7) cyc(0, 1, 0);

    // Negative ramp (N=5 instance sees -1..-5)
    fill(-1, -1);
    cyc(1, 1, 0);
    repeat (6) cyc(0, 1, 0);

    // Reset while ce is low still flushes
    fill(7, 3);
    repeat (2) cyc(1, 1, 0);
    cyc(1, 0, 1);
    cyc(0, 0, 0);
    repeat (7) cyc(0, 1, 0);

    // Random samples, valid and stalls
    for (int t = 0; t < 60; t++) begin
      for (int k = 0; k < 10; k++) smp[k] = int'($urandom_range(0, 262143)) - 131072;
      cyc(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, 1'b0);
    end

    fill(0, 0);
    repeat (10) cyc(0, 1, 0);
    for (int d = 0; d < ND; d++) begin
      check_val($sformatf("drain_d%0d", d), longint'(q_due[d].size()), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
